// File: rtl/line_buf_pkg.sv
// Shared types and helpers for the multi-line delay buffer (line_buffer_multi).
// Default geometry: 1920-pixel lines, 8-bit pixels, 3 taps per column.
package line_buf_pkg;

    localparam int MAX_LINE_WIDTH_DEF = 1920;
    localparam int DATA_WIDTH_DEF     = 8;
    localparam int NUM_LINES_DEF      = 3;

    localparam int COL_W = $clog2(MAX_LINE_WIDTH_DEF);
    localparam int ROW_W = $clog2(NUM_LINES_DEF) + 1;

    typedef logic [DATA_WIDTH_DEF-1:0] pix_t;

    // A zero or oversized line length selects the full line width.
    function automatic int unsigned sat_len(input int unsigned len, input int unsigned max_len);
        if (len == 0 || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/line_buffer_multi_line_mem.sv
// line_mem: simple dual-port line memory with a registered read port.
// A read and a write to the same address in one cycle return the old word.
module line_mem #(
    parameter int DEPTH = 1920,
    parameter int AW    = 11,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage write and registered read; the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_multi.sv
// line_buffer_multi: runtime-configurable N-line delay buffer feeding the Sobel window.
// Each accepted pixel yields a column of NUM_LINES taps one cycle later.
// Build option LINE_BUF_REPLICATE_EN: unfilled upper taps repeat the topmost
// filled row instead of reading as zero.
module line_buffer_multi
    import line_buf_pkg::*;
#(
    parameter int MAX_LINE_WIDTH = 1920,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_LINES      = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(MAX_LINE_WIDTH):0] line_len,
    input  logic                            sof,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            data_valid,
    output logic [NUM_LINES*DATA_WIDTH-1:0] taps,
    output logic                            taps_valid,
    output logic                            taps_eol,
    output logic [$clog2(NUM_LINES):0]      rows_filled
);

    localparam int CW = $clog2(MAX_LINE_WIDTH);
    localparam int LW = CW + 1;
    localparam int RW = $clog2(NUM_LINES) + 1;

    logic [CW-1:0]         col_q;
    logic [LW-1:0]         len_q;
    logic [RW-1:0]         rows_q;
    logic [RW-1:0]         rf_q;
    logic                  vld_q;
    logic                  eol_q;
    logic [DATA_WIDTH-1:0] tap0_q;
    logic [CW-1:0]         wcol_q;

    logic                  sof_acc;
    logic [LW-1:0]         len_d;
    logic [CW-1:0]         col_cur;
    logic                  eol;
    logic [RW-1:0]         rows_base;
    logic [RW-1:0]         rows_d;

    // Raw (unmasked) column: index 0 is the current row, k is k rows above.
    logic [DATA_WIDTH-1:0] eff [NUM_LINES];
    logic [DATA_WIDTH-1:0] mem_q [1:NUM_LINES-1];

    // Column position, effective length and row count for the pixel being accepted.
    always_comb begin
        sof_acc   = sof & data_valid;
        len_d     = sof_acc ? LW'(sat_len(32'(line_len), MAX_LINE_WIDTH)) : len_q;
        col_cur   = sof_acc ? '0 : col_q;
        eol       = ({1'b0, col_cur} == (len_d - LW'(1)));
        rows_base = sof_acc ? '0 : rows_q;
        rows_d    = (eol && (rows_base < RW'(NUM_LINES - 1))) ? rows_base + RW'(1) : rows_base;
    end

    // Control state: column counter, line length, row fill and output strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q  <= '0;
            len_q  <= LW'(MAX_LINE_WIDTH);
            rows_q <= '0;
            rf_q   <= '0;
            vld_q  <= 1'b0;
            eol_q  <= 1'b0;
            tap0_q <= '0;
        end else begin
            vld_q <= data_valid;
            if (data_valid) begin
                len_q  <= len_d;
                col_q  <= eol ? '0 : col_cur + CW'(1);
                rows_q <= rows_d;
                rf_q   <= rows_base;
                eol_q  <= eol;
                tap0_q <= data_in;
            end
        end
    end

    // Column of the last accepted pixel, used as the deferred write address.
    always_ff @(posedge clk) begin
        if (data_valid) begin
            wcol_q <= col_cur;
        end
    end

    assign eff[0] = tap0_q;

    // Line memory k holds, per column, the value tap k-1 had one line earlier.
    // Memory 1 stores the incoming pixel directly; deeper memories store the
    // previous memory's read word one cycle later, with a bypass for the case
    // where the next pixel reads that same column (single-pixel lines).
    for (genvar k = 1; k < NUM_LINES; k++) begin : g_line
        if (k == 1) begin : g_first
            line_mem #(
                .DEPTH (MAX_LINE_WIDTH),
                .AW    (CW),
                .DW    (DATA_WIDTH)
            ) u_mem (
                .clk     (clk),
                .we_i    (data_valid),
                .waddr_i (col_cur),
                .wdata_i (data_in),
                .re_i    (data_valid),
                .raddr_i (col_cur),
                .rdata_o (mem_q[k])
            );
            assign eff[k] = mem_q[k];
        end else begin : g_chain
            logic                  fwd_q;
            logic [DATA_WIDTH-1:0] fwd_dat_q;

            // Capture the in-flight write when the new read hits the same column.
            always_ff @(posedge clk) begin
                if (data_valid) begin
                    fwd_q     <= vld_q && (wcol_q == col_cur);
                    fwd_dat_q <= eff[k-1];
                end
            end

            line_mem #(
                .DEPTH (MAX_LINE_WIDTH),
                .AW    (CW),
                .DW    (DATA_WIDTH)
            ) u_mem (
                .clk     (clk),
                .we_i    (vld_q),
                .waddr_i (wcol_q),
                .wdata_i (eff[k-1]),
                .re_i    (data_valid),
                .raddr_i (col_cur),
                .rdata_o (mem_q[k])
            );
            assign eff[k] = fwd_q ? fwd_dat_q : mem_q[k];
        end
    end

    // Present each tap, blanking (or replicating) rows not yet filled for that pixel.
    always_comb begin
        logic [DATA_WIDTH-1:0] top_row;
        top_row = eff[0];
        for (int j = 1; j < NUM_LINES; j++) begin
            if (RW'(j) == rf_q) begin
                top_row = eff[j];
            end
        end
        taps = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            if (RW'(k) <= rf_q) begin
                taps[k*DATA_WIDTH +: DATA_WIDTH] = eff[k];
            end else begin
`ifdef LINE_BUF_REPLICATE_EN
                taps[k*DATA_WIDTH +: DATA_WIDTH] = top_row;
`else
                taps[k*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
            end
        end
    end

    assign taps_valid  = vld_q;
    assign taps_eol    = vld_q & eol_q;
    assign rows_filled = rows_q;

endmodule

// File: tb/tb_line_buffer_multi.sv
// Self-checking bench for line_buffer_multi (default geometry 1920 x 8-bit x 3 taps).
// Honours LINE_BUF_REPLICATE_EN when the build defines it.
module tb_line_buffer_multi;
    import line_buf_pkg::*;

    localparam int MAXW = 1920;
    localparam int DW   = 8;
    localparam int NL   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [11:0]       line_len;
    logic              sof;
    logic [DW-1:0]     data_in;
    logic              data_valid;
    logic [NL*DW-1:0]  taps;
    logic              taps_valid;
    logic              taps_eol;
    logic [2:0]        rows_filled;

    line_buffer_multi #(
        .MAX_LINE_WIDTH (MAXW),
        .DATA_WIDTH     (DW),
        .NUM_LINES      (NL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_len    (line_len),
        .sof         (sof),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .taps        (taps),
        .taps_valid  (taps_valid),
        .taps_eol    (taps_eol),
        .rows_filled (rows_filled)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscomp = 0;

    // Reference model: a picture indexed by absolute row (mod NL) and column.
    pix_t       img [NL][MAXW];
    int         m_col, m_len, m_row;
    logic [NL*DW-1:0] exp_taps;
    logic       exp_valid, exp_eol;
    logic [2:0] exp_rows;
    bit         chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit dv, input bit sf, input pix_t d, input int len);
        int rf;
        pix_t v;
        bit e;
        if (!r) begin
            m_col = 0; m_len = MAXW; m_row = 0;
            exp_taps = '0; exp_valid = 0; exp_eol = 0; exp_rows = 0;
            return;
        end
        exp_valid = dv;
        exp_eol   = 0;
        if (!dv) return;
        if (sf) begin
            m_len = (len == 0 || len > MAXW) ? MAXW : len;
            m_col = 0;
            m_row = 0;
        end
        rf = (m_row < NL - 1) ? m_row : NL - 1;
        img[m_row % NL][m_col] = d;
        for (int k = 0; k < NL; k++) begin
            if (k <= rf) v = img[(m_row - k) % NL][m_col];
`ifdef LINE_BUF_REPLICATE_EN
            else v = img[(m_row - rf) % NL][m_col];
`else
            else v = '0;
`endif
            exp_taps[k*DW +: DW] = v;
        end
        e = (m_col == m_len - 1);
        exp_eol  = e;
        exp_rows = 3'(((m_row + int'(e)) < NL - 1) ? (m_row + int'(e)) : NL - 1);
        if (e) begin
            m_col = 0;
            m_row++;
        end else begin
            m_col++;
        end
    endtask

    // Drive one cycle, advance the model at the edge, return at the following negedge.
    task automatic step(input bit r, input bit dv, input bit sf, input pix_t d, input logic [11:0] len);
        rst_n = r; data_valid = dv; sof = sf; data_in = d; line_len = len;
        @(posedge clk);
        model_step(r, dv, sf, d, int'(len));
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("taps", 64'(taps), 64'(exp_taps));
            chk("taps_valid", 64'(taps_valid), 64'(exp_valid));
            chk("taps_eol", 64'(taps_eol), 64'(exp_eol));
            chk("rows_filled", 64'(rows_filled), 64'(exp_rows));
        end
    end

    logic [11:0] lens [11] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5,
                               12'd7, 12'd16, 12'd4095, 12'd1920, 12'd1921};

    initial begin
        rst_n = 0; data_valid = 0; sof = 0; data_in = '0; line_len = 12'd4;

        // Reset state
        step(0, 0, 0, 8'd0, 12'd4);
        step(0, 0, 0, 8'd0, 12'd4);
        chk("reset_taps", 64'(taps), 64'd0);
        chk("reset_rows", 64'(rows_filled), 64'd0);

        // Test 1: line_len 4, pixels 1..12 back to back
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, i == 1, pix_t'(i), 12'd4);
            if (i == 2) begin
`ifdef LINE_BUF_REPLICATE_EN
                chk("t1_px2", 64'(taps), 64'h020202);
`else
                chk("t1_px2", 64'(taps), 64'h000002);
`endif
            end
            if (i == 5) begin
`ifdef LINE_BUF_REPLICATE_EN
                chk("t1_px5", 64'(taps), 64'h010105);
`else
                chk("t1_px5", 64'(taps), 64'h000105);
`endif
            end
            if (i == 9) chk("t1_px9", 64'(taps), 64'h010509);
            if (i == 4) chk("t1_rows4", 64'(rows_filled), 64'd1);
            if (i == 12) chk("t1_rows12", 64'(rows_filled), 64'd2);
            chk("t1_eol", 64'(taps_eol), 64'((i % 4) == 0));
        end

        // Test 2: same stream with single-cycle gaps
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, i == 1, pix_t'(i), 12'd4);
            if (i == 9) chk("t2_px9", 64'(taps), 64'h010509);
            step(1, 0, 0, 8'hAA, 12'd4);
            chk("t2_gap_valid", 64'(taps_valid), 64'd0);
        end

        // Test 3: line_len 0 selects full width; mid-frame length change ignored
        for (int i = 1; i <= MAXW + 4; i++) begin
            step(1, 1, i == 1, pix_t'($urandom), (i == 1) ? 12'd0 : 12'd8);
            if (i == 8) chk("t3_no_eol8", 64'(taps_eol), 64'd0);
            if (i == MAXW) chk("t3_eol1920", 64'(taps_eol), 64'd1);
        end

        // Test 4: sof re-asserted at column 2 of row 1
        for (int i = 1; i <= 6; i++) step(1, 1, i == 1, pix_t'(i), 12'd4);
        step(1, 1, 1, 8'd77, 12'd4);
        chk("t4_rows", 64'(rows_filled), 64'd0);
`ifdef LINE_BUF_REPLICATE_EN
        chk("t4_taps", 64'(taps), 64'h4D4D4D);
`else
        chk("t4_taps", 64'(taps), 64'h00004D);
`endif

        // Test 5: one-cycle reset mid-row, then a fresh frame
        for (int i = 1; i <= 6; i++) step(1, 1, i == 1, pix_t'(i + 20), 12'd4);
        step(0, 1, 0, 8'd99, 12'd4);
        chk("t5_taps", 64'(taps), 64'd0);
        chk("t5_valid", 64'(taps_valid), 64'd0);
        for (int i = 1; i <= 12; i++) step(1, 1, i == 1, pix_t'(i + 40), 12'd4);
        chk("t5_px12", 64'(taps), 64'h2C3034);

        // Randomized traffic: gaps, sof anywhere, odd lengths, rare resets
        for (int i = 0; i < 3000; i++) begin
            bit dv, sf, r;
            r  = ($urandom_range(0, 199) != 0);
            dv = ($urandom_range(0, 9) < 7);
            sf = dv && ($urandom_range(0, 39) == 0);
            step(r, dv, sf, pix_t'($urandom), lens[$urandom_range(0, 10)]);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
